row_by_vector_scheduler: RTL and testbench
==========================================

// Module: row_by_vector_scheduler
// PURPOSE
//  Sequences the row-by-vector engine over a whole matrix-vector product A*p.
//  For each row: waits for engine ready, pulses start, issues one chunk-read per
//  NI-wide multiple, captures the scalar result and writes it to the result buffer.
//  Sits between the row/vector chunk memories, the engine and the result RAM.
// PARAMETERS
//  NI            8     elements per chunk (engine multiplier count)
//  element_width 32    bits per element / result
//  ROW_W         10    row index width (max 2^ROW_W rows)
//  CHUNK_W       8     chunk index width (max 2^CHUNK_W multiples per row)
//  TIMEOUT       1024  max cycles waiting for engine ready or result before abort
// PORTS
//  clk              in   1              clock, rising edge
//  reset            in   1              async, active-low; 0 = reset
//  start            in   1              pulse: begin product (sampled only in IDLE)
//  no_of_rows       in   ROW_W+1        rows to process (latched on start)
//  no_of_multiples  in   CHUNK_W+1      chunks per row (latched on start)
//  eng_ready        in   1              engine I_am_ready
//  eng_give_me      in   1              engine give_me_only: wants next chunk
//  eng_result_valid in   1              engine decoder_read_now: result valid
//  eng_result       in   element_width  engine result
//  eng_start        out  1              one-cycle start_row_by_vector pulse
//  chunk_rd_en      out  1              one-cycle read strobe for chunk memories
//  chunk_row        out  ROW_W          row index of current read
//  chunk_idx        out  CHUNK_W        chunk index of current read
//  res_wr_en        out  1              one-cycle result RAM write strobe
//  res_addr         out  ROW_W          result RAM address (= row index)
//  res_data         out  element_width  result RAM data
//  busy             out  1              high from accepted start until done
//  done             out  1              one-cycle pulse at end (normal or abort)
//  err_timeout      out  1              sticky; set on watchdog abort
//  err_protocol     out  1              sticky; result before all chunks issued
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0; takes effect immediately.
//  All outputs registered. States IDLE, WAIT_RDY, START, FEED, WAIT_RES, WRITE, FIN.
//  IDLE: on start: latch sizes; no_of_multiples==0 treated as 1; busy<=1;
//    no_of_rows==0 -> FIN directly (no eng_start, no reads); else WAIT_RDY, row=0.
//  WAIT_RDY: on eng_ready -> START. START: eng_start=1 for exactly one cycle,
//    chunk_rd_en=1 with chunk_idx=0 same cycle; issued=1 -> FEED.
//  FEED: each cycle with eng_give_me and issued<multiples: chunk_rd_en pulse next
//    cycle, chunk_idx=issued, issued++. issued==multiples -> WAIT_RES.
//    eng_give_me after all issued: ignored.
//  eng_result_valid in START/FEED: err_protocol<=1, result still captured -> WRITE.
//  WAIT_RES: on eng_result_valid capture eng_result -> WRITE.
//  WRITE: res_wr_en=1 one cycle, res_addr=row, res_data=captured; then
//    row==no_of_rows-1 -> FIN, else row++, issued=0 -> WAIT_RDY.
//  FIN: done=1 one cycle, busy<=0 same edge -> IDLE. start in FIN or busy: ignored.
//  Watchdog: counter cleared on state change; WAIT_RDY or WAIT_RES reaching TIMEOUT
//    cycles -> err_timeout<=1, -> FIN (no write for that row).
//  err_* cleared only by reset or accepted start.
//  chunk_row always equals current row; indices never wrap (sizes bounded by widths).
//  Rows processed strictly in order; at most one row in flight.
// TESTING
//  rows=3, multiples=3, engine model answers row r with 100+r -> 3 eng_start pulses,
//    9 chunk reads (row,idx)=(0,0..2),(1,0..2),(2,0..2), writes addr0..2=100..102, done once.
//  rows=0 -> done 1 cycle after start accepted, no eng_start/chunk_rd_en/res_wr_en.
//  multiples=0, rows=1 -> exactly one chunk read idx 0, one write.
//  eng_ready held low 1024 cycles on row 1 of 2 -> err_timeout=1, done, only addr0 written.
//  result_valid after first chunk (multiples=4) -> err_protocol=1, write occurs, next row runs.
//  reset asserted mid-FEED -> outputs 0 asynchronously; new start restarts at row 0 cleanly.

Source files
------------

// File: rtl/row_by_vector_scheduler.sv
// Row-by-vector scheduler: walks every row of A*p through the engine, feeds chunk reads,
// and writes each scalar result to the result RAM, with watchdog and protocol flags.
module row_by_vector_scheduler #(
    parameter int NI            = 8,
    parameter int element_width = 32,
    parameter int ROW_W         = 10,
    parameter int CHUNK_W       = 8,
    parameter int TIMEOUT       = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ROW_W:0]           no_of_rows,
    input  logic [CHUNK_W:0]         no_of_multiples,
    input  logic                     eng_ready,
    input  logic                     eng_give_me,
    input  logic                     eng_result_valid,
    input  logic [element_width-1:0] eng_result,
    output logic                     eng_start,
    output logic                     chunk_rd_en,
    output logic [ROW_W-1:0]         chunk_row,
    output logic [CHUNK_W-1:0]       chunk_idx,
    output logic                     res_wr_en,
    output logic [ROW_W-1:0]         res_addr,
    output logic [element_width-1:0] res_data,
    output logic                     busy,
    output logic                     done,
    output logic                     err_timeout,
    output logic                     err_protocol,
    output logic [2:0]               state_dbg
);

    localparam int WD_W = $clog2(TIMEOUT);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_RDY = 3'd1;
    localparam logic [2:0] S_START    = 3'd2;
    localparam logic [2:0] S_FEED     = 3'd3;
    localparam logic [2:0] S_WAIT_RES = 3'd4;
    localparam logic [2:0] S_WRITE    = 3'd5;
    localparam logic [2:0] S_FIN      = 3'd6;

    generate
        if (NI < 1 || TIMEOUT < 2) begin : g_bad_params
            $error("row_by_vector_scheduler: NI must be >= 1 and TIMEOUT >= 2");
        end
    endgenerate

    logic [2:0]         state;
    logic [ROW_W:0]     rows_l;
    logic [CHUNK_W:0]   mult_l;
    logic [CHUNK_W:0]   issued;
    logic [ROW_W-1:0]   row;
    logic [WD_W-1:0]    wd;
    logic               wd_expired;
    logic               last_row;
    logic               early_result;
    logic               capture;

    assign wd_expired   = (wd == WD_W'(TIMEOUT - 1));
    assign last_row     = ({1'b0, row} == rows_l - 1'b1);
    // A result while chunks are still owed to the engine is a protocol violation,
    // but it is still written so the row sequence keeps moving.
    assign early_result = eng_result_valid && (state == S_START || state == S_FEED);
    assign capture      = early_result || (eng_result_valid && state == S_WAIT_RES);
    assign chunk_row    = row;
    assign state_dbg    = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            rows_l       <= '0;
            mult_l       <= '0;
            issued       <= '0;
            row          <= '0;
            wd           <= '0;
            eng_start    <= 1'b0;
            chunk_rd_en  <= 1'b0;
            chunk_idx    <= '0;
            res_wr_en    <= 1'b0;
            res_addr     <= '0;
            res_data     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_timeout  <= 1'b0;
            err_protocol <= 1'b0;
        end else begin
            eng_start   <= 1'b0;
            chunk_rd_en <= 1'b0;
            res_wr_en   <= 1'b0;
            done        <= 1'b0;
            wd          <= '0;
            if (capture) begin
                res_wr_en <= 1'b1;
                res_addr  <= row;
                res_data  <= eng_result;
                state     <= S_WRITE;
                if (early_result) err_protocol <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            rows_l       <= no_of_rows;
                            mult_l       <= (no_of_multiples == '0) ? (CHUNK_W+1)'(1) : no_of_multiples;
                            busy         <= 1'b1;
                            err_timeout  <= 1'b0;
                            err_protocol <= 1'b0;
                            row          <= '0;
                            issued       <= '0;
                            state        <= (no_of_rows == '0) ? S_FIN : S_WAIT_RDY;
                        end
                    end
                    S_WAIT_RDY: begin
                        if (eng_ready) begin
                            eng_start   <= 1'b1;
                            chunk_rd_en <= 1'b1;
                            chunk_idx   <= '0;
                            issued      <= (CHUNK_W+1)'(1);
                            state       <= S_START;
                        end else if (wd_expired) begin
                            err_timeout <= 1'b1;
                            state       <= S_FIN;
                        end else begin
                            wd <= wd + 1'b1;
                        end
                    end
                    S_START: state <= (issued == mult_l) ? S_WAIT_RES : S_FEED;
                    S_FEED: begin
                        if (eng_give_me) begin
                            chunk_rd_en <= 1'b1;
                            chunk_idx   <= issued[CHUNK_W-1:0];
                            issued      <= issued + 1'b1;
                            if (issued + 1'b1 == mult_l) state <= S_WAIT_RES;
                        end
                    end
                    S_WAIT_RES: begin
                        if (wd_expired) begin
                            err_timeout <= 1'b1;
                            state       <= S_FIN;
                        end else begin
                            wd <= wd + 1'b1;
                        end
                    end
                    S_WRITE: begin
                        if (last_row) begin
                            state <= S_FIN;
                        end else begin
                            row    <= row + 1'b1;
                            issued <= '0;
                            state  <= S_WAIT_RDY;
                        end
                    end
                    S_FIN: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_row_by_vector_scheduler.sv
// Bench for row_by_vector_scheduler: a randomized engine model drives the handshake while
// a scoreboard checks every chunk read, result write, done pulse and error flag.
module tb_row_by_vector_scheduler;
    localparam int ROW_W   = 10;
    localparam int CHUNK_W = 8;
    localparam int EW      = 32;
    localparam int TIMEOUT = 1024;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [ROW_W:0]    no_of_rows = '0;
    logic [CHUNK_W:0]  no_of_multiples = '0;
    logic              eng_ready = 1'b0;
    logic              eng_give_me = 1'b0;
    logic              eng_result_valid = 1'b0;
    logic [EW-1:0]     eng_result = '0;
    logic              eng_start, chunk_rd_en, res_wr_en, busy, done, err_timeout, err_protocol;
    logic [ROW_W-1:0]  chunk_row, res_addr;
    logic [CHUNK_W-1:0] chunk_idx;
    logic [EW-1:0]     res_data;
    logic [2:0]        state_dbg;

    row_by_vector_scheduler #(
        .NI(8), .element_width(EW), .ROW_W(ROW_W), .CHUNK_W(CHUNK_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .no_of_rows(no_of_rows), .no_of_multiples(no_of_multiples),
        .eng_ready(eng_ready), .eng_give_me(eng_give_me),
        .eng_result_valid(eng_result_valid), .eng_result(eng_result),
        .eng_start(eng_start), .chunk_rd_en(chunk_rd_en),
        .chunk_row(chunk_row), .chunk_idx(chunk_idx),
        .res_wr_en(res_wr_en), .res_addr(res_addr), .res_data(res_data),
        .busy(busy), .done(done), .err_timeout(err_timeout), .err_protocol(err_protocol),
        .state_dbg(state_dbg)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard state
    logic [ROW_W+CHUNK_W-1:0] exp_rd_q[$];
    logic [ROW_W+EW-1:0]      exp_wr_q[$];
    logic [ROW_W+CHUNK_W-1:0] rd_e;
    logic [ROW_W+EW-1:0]      wr_e;
    logic [EW-1:0]            val[0:63];
    int rd_seen, wr_seen, start_count, done_count = 0;
    int exp_rd_n, exp_wr_n, exp_starts;
    bit exp_terr, exp_perr;

    // Engine model configuration and state
    int block_row = -1, early_row = -1, mult_eff = 1;
    bit eng_busy = 1'b0;
    int eng_reads, eng_target, eng_row, eng_delay;

    // Monitor + engine responder, both acting on the falling edge.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            eng_busy = 1'b0;
            eng_ready = 1'b0;
            eng_give_me = 1'b0;
            eng_result_valid = 1'b0;
        end else begin
            if (eng_start) begin
                eng_row = start_count;
                start_count++;
                eng_busy = 1'b1;
                eng_reads = 0;
                eng_target = (eng_row == early_row) ? 1 : mult_eff;
                eng_delay = (eng_row == early_row) ? 0 : int'($urandom_range(1, 3));
            end
            if (chunk_rd_en) begin
                rd_seen++;
                eng_reads++;
                if (exp_rd_q.size() > 0) begin
                    rd_e = exp_rd_q.pop_front();
                    check("chunk_rd", {chunk_row, chunk_idx}, rd_e);
                end
            end
            if (res_wr_en) begin
                wr_seen++;
                if (exp_wr_q.size() > 0) begin
                    wr_e = exp_wr_q.pop_front();
                    check("res_wr", {res_addr, res_data}, wr_e);
                end
            end
            if (done) done_count++;
            eng_result_valid = 1'b0;
            if (eng_busy && eng_reads >= eng_target) begin
                if (eng_delay == 0) begin
                    eng_result_valid = 1'b1;
                    eng_result = val[eng_row];
                    eng_busy = 1'b0;
                end else begin
                    eng_delay--;
                end
            end
            eng_give_me = eng_busy && (eng_row != early_row) && ($urandom_range(0, 2) != 0);
            eng_ready = !eng_busy && (start_count != block_row) && ($urandom_range(0, 1) == 1);
        end
    end

    // Reference model: rows in order, one read per chunk, the blocked row and later never run,
    // an early-answering row gets only its first chunk.
    task automatic prep(input int rows, input int mult, input int blk, input int early, input bit fixed);
        int m_eff;
        m_eff = (mult == 0) ? 1 : mult;
        block_row = blk;
        early_row = early;
        mult_eff = m_eff;
        start_count = 0;
        rd_seen = 0;
        wr_seen = 0;
        exp_rd_q.delete();
        exp_wr_q.delete();
        exp_rd_n = 0;
        exp_wr_n = 0;
        exp_starts = 0;
        for (int r = 0; r < rows; r++) val[r] = fixed ? EW'(100 + r) : $urandom;
        for (int r = 0; r < rows; r++) begin
            if (r == blk) break;
            for (int i = 0; i < ((r == early) ? 1 : m_eff); i++) begin
                exp_rd_q.push_back({ROW_W'(r), CHUNK_W'(i)});
                exp_rd_n++;
            end
            exp_wr_q.push_back({ROW_W'(r), val[r]});
            exp_wr_n++;
            exp_starts++;
        end
        exp_terr = (blk >= 0) && (blk < rows);
        exp_perr = (early >= 0) && (early < rows) && !(exp_terr && blk <= early);
    endtask

    task automatic launch(input int rows, input int mult);
        @(negedge clk);
        no_of_rows = (ROW_W+1)'(rows);
        no_of_multiples = (CHUNK_W+1)'(mult);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic finish_check(input string name, input int d0, input bit noise);
        for (int c = 0; c < 6000 && done_count == d0; c++) begin
            @(negedge clk);
            if (noise && c == 4 && busy) begin
                no_of_rows = (ROW_W+1)'($urandom_range(1, 7));
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        check({name, "_done_count"}, done_count - d0, 1);
        check({name, "_busy_idle"}, busy, 0);
        check({name, "_err_timeout"}, err_timeout, exp_terr);
        check({name, "_err_protocol"}, err_protocol, exp_perr);
        check({name, "_reads"}, rd_seen, exp_rd_n);
        check({name, "_writes"}, wr_seen, exp_wr_n);
        check({name, "_starts"}, start_count, exp_starts);
        check({name, "_rd_left"}, exp_rd_q.size(), 0);
        check({name, "_wr_left"}, exp_wr_q.size(), 0);
    endtask

    task automatic run_test(input string name, input int rows, input int mult, input int blk,
                            input int early, input bit fixed, input bit noise);
        int d0;
        prep(rows, mult, blk, early, fixed);
        d0 = done_count;
        launch(rows, mult);
        finish_check(name, d0, noise);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_ctrl"}, {eng_start, chunk_rd_en, res_wr_en, busy, done, err_timeout, err_protocol}, 0);
        check({name, "_idx"}, {chunk_row, chunk_idx, res_addr}, 0);
        check({name, "_data"}, res_data, 0);
    endtask

    initial begin
        int rows, mult, early, d0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_test("basic", 3, 3, -1, -1, 1'b1, 1'b0);
        run_test("mult0", 1, 0, -1, -1, 1'b0, 1'b0);
        run_test("timeout", 2, 2, 1, -1, 1'b0, 1'b0);

        // Zero rows: busy for one cycle, done on the next, nothing issued.
        prep(0, 1, -1, -1, 1'b0);
        d0 = done_count;
        launch(0, 1);
        check("rows0_done_early", done, 0);
        @(negedge clk);
        check("rows0_done", done, 1);
        check("rows0_busy", busy, 0);
        check("rows0_err_timeout", err_timeout, 0);
        @(negedge clk);
        check("rows0_done_drop", done, 0);
        check("rows0_done_count", done_count - d0, 1);
        check("rows0_activity", rd_seen + wr_seen + start_count, 0);

        run_test("protocol", 3, 4, -1, 0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of feeding chunks.
        prep(3, 8, -1, -1, 1'b0);
        launch(3, 8);
        for (int c = 0; c < 300 && rd_seen < 3; c++) @(negedge clk);
        check("midreset_reached_feed", rd_seen >= 3, 1);
        #2 reset = 1'b0;
        #1 check_outputs_zero("midreset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run_test("after_reset", 3, 5, -1, -1, 1'b0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            rows = int'($urandom_range(1, 6));
            mult = int'($urandom_range(0, 5));
            early = -1;
            if (mult >= 2 && $urandom_range(0, 2) == 0) early = int'($urandom_range(0, rows - 1));
            run_test("random", rows, mult, -1, early, 1'b0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "global timeout");
    end

endmodule
